// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//
// Circular buffer of retired-instruction records for trace/debug capture.
// Each accepted record is normalised (writes to x0 or with rd_we=0 carry no
// data), tagged with a free-running 32-bit retire sequence number and held
// until the consumer pops it. When the buffer is full it either back-pressures
// the commit stream (OVERWRITE=0) or discards the oldest record (OVERWRITE=1),
// counting the discards in a saturating 16-bit counter.
//
// Parameters
//   XLEN       width of pc / npc / rd_data
//   DEPTH      number of entries; power of two, >= 2
//   OVERWRITE  0: back-pressure when full, 1: discard oldest when full
//
// Ports
//   clk, rstn                 clock (rising edge), async active-low reset
//   flush                     synchronous clear; overrides push/pop that cycle
//   commit_valid/ready        record offer / acceptance handshake
//   commit_pc/npc/inst        retired instruction identity
//   commit_rd_we/id/data      register writeback of the retired instruction
//   out_valid/ready           head record available / consumer takes it
//   out_pc..out_rd_data       head record fields, zero while out_valid=0
//   out_seq                   retire sequence number of the head record
//   count                     records currently held
//   dropped                   records discarded in OVERWRITE mode (saturating)
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned OVERWRITE = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,

  input  logic                     commit_valid,
  output logic                     commit_ready,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [XLEN-1:0]          commit_npc,
  input  logic [31:0]              commit_inst,
  input  logic                     commit_rd_we,
  input  logic [4:0]               commit_rd_id,
  input  logic [XLEN-1:0]          commit_rd_data,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_npc,
  output logic [31:0]              out_inst,
  output logic                     out_rd_we,
  output logic [4:0]               out_rd_id,
  output logic [XLEN-1:0]          out_rd_data,
  output logic [31:0]              out_seq,

  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              dropped
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam bit          OVW = (OVERWRITE != 0);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [31:0]     inst;
    logic            rd_we;
    logic [4:0]      rd_id;
    logic [XLEN-1:0] rd_data;
    logic [31:0]     seq;
  } rec_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] head_q,    head_d;
  logic [PW-1:0] tail_q,    tail_d;
  logic [CW-1:0] count_q,   count_d;
  logic [15:0]   dropped_q, dropped_d;
  logic [31:0]   seq_q,     seq_d;

  rec_t          mem_q [DEPTH];
  rec_t          wr_rec;
  rec_t          head_rec;

  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          drop;
  logic          rd_live;

  // ---------------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------------
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign commit_ready = OVW ? 1'b1 : !full;
  assign out_valid    = !empty;

  // flush wins over both handshakes, so neither pointer moves in a flush cycle.
  assign push_ok = commit_valid && commit_ready && !flush;
  assign pop_ok  = out_valid    && out_ready    && !flush;

  // A push into a full buffer with no pop can only happen in OVERWRITE mode
  // (commit_ready is low otherwise); the oldest record is sacrificed. Since
  // head==tail when full, writing at tail replaces exactly that record.
  assign drop = OVW && push_ok && full && !pop_ok;

  // Writes to x0 or without a write enable carry no architectural data.
  assign rd_live = commit_rd_we && (commit_rd_id != 5'd0);

  always_comb begin
    wr_rec         = '0;
    wr_rec.pc      = commit_pc;
    wr_rec.npc     = commit_npc;
    wr_rec.inst    = commit_inst;
    wr_rec.rd_we   = rd_live;
    wr_rec.rd_id   = commit_rd_id;
    wr_rec.rd_data = rd_live ? commit_rd_data : '0;
    wr_rec.seq     = seq_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    seq_d     = seq_q;

    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      dropped_d = '0;
    end else begin
      if (push_ok) begin
        tail_d = tail_q + PW'(1);
        seq_d  = seq_q + 32'd1;
      end

      if (pop_ok || drop) begin
        head_d = head_q + PW'(1);
      end

      if (drop) begin
        if (dropped_q != 16'hFFFF) begin
          dropped_d = dropped_q + 16'd1;
        end
      end else if (push_ok && !pop_ok) begin
        count_d = count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    if (!rstn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      seq_q     <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      seq_q     <= seq_d;
    end
  end

  // NOTE: the record storage is deliberately not reset; an entry is only ever
  // read while count says it holds a record, and the outputs are gated to
  // zero otherwise, so a reset would buy nothing but a large reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[tail_q] <= wr_rec;
    end
  end

  // ---------------------------------------------------------------------------
  // Head record presentation (no bypass: a record is visible only after it
  // has been written into the array)
  // ---------------------------------------------------------------------------
  assign head_rec = mem_q[head_q];

  assign out_pc      = out_valid ? head_rec.pc      : '0;
  assign out_npc     = out_valid ? head_rec.npc     : '0;
  assign out_inst    = out_valid ? head_rec.inst    : '0;
  assign out_rd_we   = out_valid ? head_rec.rd_we   : 1'b0;
  assign out_rd_id   = out_valid ? head_rec.rd_id   : '0;
  assign out_rd_data = out_valid ? head_rec.rd_data : '0;
  assign out_seq     = out_valid ? head_rec.seq     : '0;

  assign count   = count_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Two DEPTH=4 instances share one stimulus stream: index 0 back-pressures
// (OVERWRITE=0), index 1 discards oldest (OVERWRITE=1). A reference model per
// instance is a plain queue of expected records; a negedge monitor compares
// every visible output against it and then applies the rules for the coming
// edge. Directed sequences add explicit checks for the called-out scenarios,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_commit_trace_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  id;
    logic [63:0] data;
    logic [31:0] seq;
  } rec_t;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        flush = 1'b0;
  logic        cv    = 1'b0;
  logic [63:0] cpc   = '0;
  logic [63:0] cnpc  = '0;
  logic [31:0] cinst = '0;
  logic        cwe   = 1'b0;
  logic [4:0]  cid   = '0;
  logic [63:0] cdata = '0;
  logic        ordy  = 1'b0;

  logic        crdy  [2];
  logic        ov    [2];
  logic [63:0] opc   [2];
  logic [63:0] onpc  [2];
  logic [31:0] oinst [2];
  logic        owe   [2];
  logic [4:0]  oid   [2];
  logic [63:0] odata [2];
  logic [31:0] oseq  [2];
  logic [2:0]  cnt   [2];
  logic [15:0] drp   [2];

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .OVERWRITE(0)) u_dut_bp (
    .clk(clk), .rstn(rstn), .flush(flush),
    .commit_valid(cv), .commit_ready(crdy[0]),
    .commit_pc(cpc), .commit_npc(cnpc), .commit_inst(cinst),
    .commit_rd_we(cwe), .commit_rd_id(cid), .commit_rd_data(cdata),
    .out_valid(ov[0]), .out_ready(ordy),
    .out_pc(opc[0]), .out_npc(onpc[0]), .out_inst(oinst[0]),
    .out_rd_we(owe[0]), .out_rd_id(oid[0]), .out_rd_data(odata[0]),
    .out_seq(oseq[0]), .count(cnt[0]), .dropped(drp[0])
  );

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .OVERWRITE(1)) u_dut_ow (
    .clk(clk), .rstn(rstn), .flush(flush),
    .commit_valid(cv), .commit_ready(crdy[1]),
    .commit_pc(cpc), .commit_npc(cnpc), .commit_inst(cinst),
    .commit_rd_we(cwe), .commit_rd_id(cid), .commit_rd_data(cdata),
    .out_valid(ov[1]), .out_ready(ordy),
    .out_pc(opc[1]), .out_npc(onpc[1]), .out_inst(oinst[1]),
    .out_rd_we(owe[1]), .out_rd_id(oid[1]), .out_rd_data(odata[1]),
    .out_seq(oseq[1]), .count(cnt[1]), .dropped(drp[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + monitor
  // ---------------------------------------------------------------------------
  rec_t        mq    [2][$];
  logic [31:0] mseq  [2] = '{32'd0, 32'd0};
  logic [15:0] mdrop [2] = '{16'd0, 16'd0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit    ow;
      bit    exp_rdy;
      bit    do_pop;
      bit    do_push;
      bit    live;
      rec_t  r;
      string t;
      ow = (d == 1);
      t  = ow ? "ow" : "bp";

      if (!rstn) begin
        mq[d].delete();
        mseq[d]  = 32'd0;
        mdrop[d] = 16'd0;
      end

      exp_rdy = ow || (mq[d].size() < DEPTH);
      check({t, ".count"},        64'(cnt[d]),  64'(mq[d].size()));
      check({t, ".dropped"},      64'(drp[d]),  64'(mdrop[d]));
      check({t, ".commit_ready"}, 64'(crdy[d]), 64'(exp_rdy));
      check({t, ".out_valid"},    64'(ov[d]),   64'(mq[d].size() != 0));

      if (mq[d].size() != 0) begin
        r = mq[d][0];
      end else begin
        r = '{default: '0};
      end
      check({t, ".out_pc"},      opc[d],          r.pc);
      check({t, ".out_npc"},     onpc[d],         r.npc);
      check({t, ".out_inst"},    64'(oinst[d]),   64'(r.inst));
      check({t, ".out_rd_we"},   64'(owe[d]),     64'(r.we));
      check({t, ".out_rd_id"},   64'(oid[d]),     64'(r.id));
      check({t, ".out_rd_data"}, odata[d],        r.data);
      check({t, ".out_seq"},     64'(oseq[d]),    64'(r.seq));

      // Apply the rules for the upcoming rising edge.
      if (rstn) begin
        if (flush) begin
          mq[d].delete();
          mdrop[d] = 16'd0;
        end else begin
          do_pop  = ordy && (mq[d].size() != 0);
          do_push = cv && exp_rdy;
          if (do_pop) void'(mq[d].pop_front());
          if (do_push) begin
            if (mq[d].size() == DEPTH) begin
              void'(mq[d].pop_front());
              if (mdrop[d] != 16'hFFFF) mdrop[d] = mdrop[d] + 16'd1;
            end
            live = cwe && (cid != 5'd0);
            mq[d].push_back('{pc: cpc, npc: cnpc, inst: cinst, we: live,
                              id: cid, data: live ? cdata : 64'd0, seq: mseq[d]});
            mseq[d] = mseq[d] + 32'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a rising edge and are
  // sampled at the following rising edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input logic [63:0] pc, input bit we,
                       input logic [4:0] id, input logic [63:0] data,
                       input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    cv    = v;
    cpc   = pc;
    cnpc  = pc + 64'd4;
    cinst = pc[31:0] ^ 32'hA5A5_0013;
    cwe   = we;
    cid   = id;
    cdata = data;
    ordy  = rdy;
    flush = fl;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, rdy, 1'b0);
  endtask

  task automatic push(input logic [63:0] pc, input bit rdy);
    drive(1'b1, pc, 1'b1, 5'd3, pc ^ 64'h55, rdy, 1'b0);
  endtask

  task automatic do_reset();
    idle(1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequences
  // ---------------------------------------------------------------------------
  initial begin
    @(posedge clk);
    #1;
    // Reset state while rstn is held low.
    for (int d = 0; d < 2; d++) begin
      check("rst.out_valid",    64'(ov[d]),   64'd0);
      check("rst.count",        64'(cnt[d]),  64'd0);
      check("rst.commit_ready", 64'(crdy[d]), 64'd1);
      check("rst.dropped",      64'(drp[d]),  64'd0);
      check("rst.out_pc",       opc[d],       64'd0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Fill with back-pressure, fifth offer ignored by bp, dropped by ow.
    for (int i = 0; i < 5; i++) push(64'h100 + 64'(4 * i), 1'b0);
    idle(1'b0);
    check("fill.bp.count", 64'(cnt[0]),  64'd4);
    check("fill.bp.ready", 64'(crdy[0]), 64'd0);
    check("fill.ow.count", 64'(cnt[1]),  64'd4);
    check("fill.ow.drop",  64'(drp[1]),  64'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("drain.bp.pc",  opc[0],        64'h100 + 64'(4 * i));
      check("drain.bp.seq", 64'(oseq[0]),  64'(i));
    end
    idle(1'b0);
    check("drain.bp.count", 64'(cnt[0]), 64'd0);
    check("drain.bp.valid", 64'(ov[0]),  64'd0);

    // Overwrite: six pushes into four entries.
    do_reset();
    for (int i = 0; i < 6; i++) push(64'(4 * i), 1'b0);
    idle(1'b0);
    check("ovw.count",  64'(cnt[1]),  64'd4);
    check("ovw.drop",   64'(drp[1]),  64'd2);
    check("ovw.pc",     opc[1],       64'h8);
    check("ovw.seq",    64'(oseq[1]), 64'd2);
    check("ovw.bp.pc",  opc[0],       64'h0);

    // Simultaneous push and pop while full.
    push(64'h18, 1'b1);
    idle(1'b0);
    check("pp.ow.count", 64'(cnt[1]),  64'd4);
    check("pp.ow.drop",  64'(drp[1]),  64'd2);
    check("pp.ow.pc",    opc[1],       64'hC);
    check("pp.ow.seq",   64'(oseq[1]), 64'd3);
    check("pp.bp.count", 64'(cnt[0]),  64'd3);

    // x0 normalisation.
    drive(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    drive(1'b1, 64'h200, 1'b1, 5'd0, 64'hDEAD, 1'b0, 1'b0);
    idle(1'b0);
    check("x0.we",   64'(owe[1]), 64'd0);
    check("x0.data", odata[1],    64'd0);
    idle(1'b1);
    drive(1'b1, 64'h204, 1'b1, 5'd5, 64'hDEAD, 1'b0, 1'b0);
    idle(1'b0);
    check("x5.data", odata[0],    64'hDEAD);
    check("x5.we",   64'(owe[0]), 64'd1);
    check("x5.id",   64'(oid[0]), 64'd5);

    // Flush (with a push offered in the same cycle) keeps the sequence counter.
    do_reset();
    for (int i = 0; i < 3; i++) push(64'h400 + 64'(4 * i), 1'b0);
    drive(1'b1, 64'h4F0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1);
    idle(1'b0);
    for (int d = 0; d < 2; d++) begin
      check("flush.count", 64'(cnt[d]), 64'd0);
      check("flush.valid", 64'(ov[d]),  64'd0);
      check("flush.drop",  64'(drp[d]), 64'd0);
    end
    push(64'h500, 1'b0);
    idle(1'b0);
    check("flush.seq", 64'(oseq[0]), 64'd3);
    check("flush.pc",  opc[0],       64'h500);

    // Randomized traffic; the monitor checks every cycle.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0,
            {$urandom, $urandom},
            1'($urandom),
            5'(($urandom % 3 == 0) ? 0 : $urandom),
            {$urandom, $urandom},
            ($urandom % 3) != 0,
            ($urandom % 50) == 0);
    end

    // Asynchronous reset mid-burst.
    do_reset();
    for (int i = 0; i < 3; i++) push(64'h600 + 64'(4 * i), 1'b0);
    #1;
    rstn = 1'b0;
    cv   = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("arst.valid", 64'(ov[d]),  64'd0);
      check("arst.count", 64'(cnt[d]), 64'd0);
      check("arst.pc",    opc[d],      64'd0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push(64'h300, 1'b0);
    idle(1'b0);
    check("arst.seq",    64'(oseq[0]), 64'd0);
    check("arst.pc_new", opc[0],       64'h300);

    idle(1'b0);
    idle(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of pc/npc/rd_data.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter OVERWRITE, default 0; 0 = back-pressure when full, 1 = discard oldest when full.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous clear of buffer contents.
REQ-007 SHALL have port commit_valid  input  1  retired instruction offered.
REQ-008 SHALL have port commit_ready  output  1  buffer accepts offered record.
REQ-009 SHALL have ports commit_pc / commit_npc  input  XLEN each  pc and next pc of retired instruction.
REQ-010 SHALL have port commit_inst  input  32  instruction word.
REQ-011 SHALL have ports commit_rd_we  input  1, commit_rd_id  input  5, commit_rd_data  input  XLEN  register writeback.
REQ-012 SHALL have port out_valid  output  1  head record available.
REQ-013 SHALL have port out_ready  input  1  consumer takes head record.
REQ-014 SHALL have ports out_pc, out_npc (XLEN), out_inst (32), out_rd_we (1), out_rd_id (5), out_rd_data (XLEN)  output  head record fields.
REQ-015 SHALL have port out_seq  output  32  retire sequence number of head record.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  records held.
REQ-017 SHALL have port dropped  output  16  records discarded in OVERWRITE mode, saturating.

Function
REQ-018 SHALL accept (push) a record on a rising edge where commit_valid=1 and commit_ready=1 and flush=0.
REQ-019 SHALL drive commit_ready = (count<DEPTH) when OVERWRITE=0, constant 1 when OVERWRITE=1.
REQ-020 SHALL pop the head record on a rising edge where out_valid=1 and out_ready=1 and flush=0.
REQ-021 SHALL drive out_valid = (count!=0); out_* fields combinationally from head entry; all out_* data fields 0 when out_valid=0.
REQ-022 SHALL make a pushed record visible on out_* one cycle after the accepting edge; no same-cycle bypass when empty.
REQ-023 SHALL store rd_data as 0 and rd_we as 0 when commit_rd_we=0 or commit_rd_id=0 (x0 normalisation); rd_id stored unchanged.
REQ-024 SHALL tag each pushed record with a 32-bit sequence counter value, then increment it; counter wraps 0xFFFFFFFF -> 0.
REQ-025 SHALL use head/tail pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-026 SHALL, on simultaneous push and pop, keep count unchanged, advance head and tail.
REQ-027 SHALL, in OVERWRITE=1, on push while count=DEPTH without pop: overwrite oldest, advance head and tail, count stays DEPTH, dropped increments unless already 0xFFFF.
REQ-028 SHALL, in OVERWRITE=1, on push and pop while full: no drop, dropped unchanged.
REQ-029 SHALL, on flush=1, set head=tail=0, count=0, dropped=0, ignoring any push or pop that cycle; sequence counter NOT cleared.
REQ-030 SHALL ignore out_ready when out_valid=0 and commit_valid when commit_ready=0 (no state change).

Reset
REQ-031 SHALL, on rstn=0, immediately clear head, tail, count, dropped, sequence counter to 0; out_valid=0, all out_* data 0; commit_ready=1.
REQ-032 SHALL discard all held records on reset asserted mid-operation; storage array need not be cleared.
REQ-033 SHALL resume normal push/pop on the first rising edge after rstn deasserts.

Verification
REQ-034 SHALL verify, DEPTH=4, OVERWRITE=0: push pc 0x100,0x104,0x108,0x10C, out_ready=0 -> count=4, commit_ready=0; fifth offer ignored; pop all -> pc order 0x100..0x10C, out_seq 0..3.
REQ-035 SHALL verify, DEPTH=4, OVERWRITE=1: push 6 records pc 0x0..0x14 step 4, no pop -> count=4, dropped=2, head out_pc=0x8, out_seq=2.
REQ-036 SHALL verify simultaneous push/pop when full (OVERWRITE=1) -> count=4, dropped unchanged, head advances by one.
REQ-037 SHALL verify push with rd_we=1, rd_id=0, rd_data=0xDEAD -> out_rd_we=0, out_rd_data=0; rd_id=5 same data -> out_rd_data=0xDEAD.
REQ-038 SHALL verify flush after 3 pushes -> count=0, out_valid=0, dropped=0; next push shows out_seq=3.
REQ-039 SHALL verify rstn asserted asynchronously mid-burst -> out_valid=0, count=0 without clock edge; next push shows out_seq=0.
